// File: rtl/blob_frame_ctrl_if.sv
// Camera-pixel, blob-pipeline and host signals of the frame sequencer, bundled as one port.
// The slave modport is the sequencer's view; master is the view of whatever drives it.
interface blob_frame_ctrl_if #(
  parameter int PIX_W = 8
);
  logic             i_start;
  logic             i_continuous;
  logic             i_frame_start;
  logic             i_pix_valid;
  logic [PIX_W-1:0] i_pix_gray;
  logic [PIX_W-1:0] i_threshold;
  logic             o_blob_valid;
  logic             o_blob_seq;
  logic             i_blob_done;
  logic [7:0]       i_blob_count;
  logic             o_busy;
  logic             o_result_valid;
  logic [7:0]       o_result;
  logic             o_result_err;
  logic             o_timeout;

  modport slave (
    input  i_start, i_continuous, i_frame_start, i_pix_valid, i_pix_gray, i_threshold,
    input  i_blob_done, i_blob_count,
    output o_blob_valid, o_blob_seq, o_busy, o_result_valid, o_result, o_result_err, o_timeout
  );

  modport master (
    output i_start, i_continuous, i_frame_start, i_pix_valid, i_pix_gray, i_threshold,
    output i_blob_done, i_blob_count,
    input  o_blob_valid, o_blob_seq, o_busy, o_result_valid, o_result, o_result_err, o_timeout
  );
endinterface

// File: rtl/blob_frame_ctrl.sv
// Frame sequencer: captures one binarized camera frame into the blob pipeline with fixed
// two-cycle pixel-to-seq alignment, then collects the blob count and hands it to the host.
module blob_frame_ctrl #(
  parameter int IMG_COL     = 800,
  parameter int IMG_ROW     = 600,
  parameter int PIX_W       = 8,
  parameter int TIMEOUT_CYC = 65536
) (
  input  logic             i_clk,
  input  logic             i_rst,
  blob_frame_ctrl_if.slave bus
);
  localparam int FRAME_PIX = IMG_COL * IMG_ROW;
  localparam int CNT_W     = 20;
  localparam int TO_W      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {IDLE, ARM, STREAM, FLUSH, WAIT_RES, RELEASE, DONE, HALT} state_t;

  state_t             state_q, state_d;
  logic [PIX_W-1:0]   thr_q, thr_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               flush_q, flush_d;
  logic               err_q, err_d;
  logic               under_q, under_d;
  logic               stg1_q, stg1_d;
  logic               blob_valid_q, blob_valid_d;
  logic               blob_seq_q, blob_seq_d;
  logic               busy_q, busy_d;
  logic               result_valid_q, result_valid_d;
  logic [7:0]         result_q, result_d;
  logic               result_err_q, result_err_d;
  logic               timeout_q, timeout_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= IDLE;
      thr_q          <= '0;
      pix_cnt_q      <= '0;
      to_cnt_q       <= '0;
      flush_q        <= 1'b0;
      err_q          <= 1'b0;
      under_q        <= 1'b0;
      stg1_q         <= 1'b0;
      blob_valid_q   <= 1'b0;
      blob_seq_q     <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
      result_err_q   <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      thr_q          <= thr_d;
      pix_cnt_q      <= pix_cnt_d;
      to_cnt_q       <= to_cnt_d;
      flush_q        <= flush_d;
      err_q          <= err_d;
      under_q        <= under_d;
      stg1_q         <= stg1_d;
      blob_valid_q   <= blob_valid_d;
      blob_seq_q     <= blob_seq_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
      result_q       <= result_d;
      result_err_q   <= result_err_d;
      timeout_q      <= timeout_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    thr_d          = thr_q;
    pix_cnt_d      = pix_cnt_q;
    to_cnt_d       = to_cnt_q;
    flush_d        = flush_q;
    err_d          = err_q;
    under_d        = under_q;
    blob_valid_d   = blob_valid_q;
    result_d       = result_q;
    result_err_d   = result_err_q;
    timeout_d      = timeout_q;
    result_valid_d = 1'b0;
    // The first delay stage carries 0 unless a pixel is accepted this cycle.
    stg1_d         = 1'b0;
    blob_seq_d     = stg1_q;

    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          state_d = ARM;
          err_d   = 1'b0;
        end
      end
      ARM: begin
        // Pixel 0 is binarized against the live threshold, since thr_q only loads now.
        if (bus.i_pix_valid && bus.i_frame_start) begin
          thr_d        = bus.i_threshold;
          pix_cnt_d    = CNT_W'(1);
          under_d      = 1'b0;
          stg1_d       = (bus.i_pix_gray >= bus.i_threshold);
          blob_valid_d = 1'b1;
          state_d      = STREAM;
        end
      end
      STREAM: begin
        if (under_q || !bus.i_pix_valid) begin
          under_d = 1'b1;
          err_d   = 1'b1;
        end else begin
          stg1_d = (bus.i_pix_gray >= thr_q);
          if (bus.i_frame_start) begin
            err_d = 1'b1;
          end
        end
        pix_cnt_d = pix_cnt_q + CNT_W'(1);
        if (pix_cnt_q == CNT_W'(FRAME_PIX - 1)) begin
          state_d = FLUSH;
          flush_d = 1'b0;
        end
      end
      FLUSH: begin
        flush_d = 1'b1;
        if (flush_q) begin
          state_d  = WAIT_RES;
          to_cnt_d = '0;
        end
      end
      WAIT_RES: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (bus.i_blob_done) begin
          result_d     = bus.i_blob_count;
          result_err_d = err_q;
          blob_valid_d = 1'b0;
          state_d      = RELEASE;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          timeout_d    = 1'b1;
          blob_valid_d = 1'b0;
          state_d      = HALT;
        end
      end
      RELEASE: begin
        if (!bus.i_blob_done) begin
          result_valid_d = 1'b1;
          state_d        = DONE;
        end
      end
      DONE: begin
        if (bus.i_continuous) begin
          state_d = ARM;
          err_d   = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      HALT: begin
        state_d = HALT;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.o_blob_valid   = blob_valid_q;
  assign bus.o_blob_seq     = blob_seq_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_result_valid = result_valid_q;
  assign bus.o_result       = result_q;
  assign bus.o_result_err   = result_err_q;
  assign bus.o_timeout      = timeout_q;
endmodule

// File: doc/blob_frame_ctrl.md
Name: blob_frame_ctrl

Overview:
- Frame-level sequencer for the blob-count pipeline.
- On a measurement request, it waits for the next camera frame start and binarizes each gray pixel against a sampled threshold.
- It then drives the pipeline's valid/seq inputs with the exact cycle alignment the pipeline requires, collects the count, and releases the pipeline back to idle.
- It sits between the camera pixel stream and the blob pipeline; it also reports timeout and stream-underrun errors to the host.

Parameters:
- IMG_COL, 800, pixels per row.
- IMG_ROW, 600, rows per frame.
- PIX_W, 8, gray pixel width.
- TIMEOUT_CYC, 65536, maximum cycles allowed in WAIT_RES before a timeout is declared.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous reset, active-high.
- i_start  in  1  one-cycle measurement request; honoured only in IDLE.
- i_continuous  in  1  when 1, the block re-arms automatically after each result.
- i_frame_start  in  1  qualifies the first pixel of a frame; valid only together with i_pix_valid.
- i_pix_valid  in  1  pixel qualifier.
- i_pix_gray  in  PIX_W  gray pixel value.
- i_threshold  in  PIX_W  binarization threshold.
- o_blob_valid  out  1  drives the pipeline i_valid.
- o_blob_seq  out  1  drives the pipeline i_seq.
- i_blob_done  in  1  pipeline o_valid.
- i_blob_count  in  8  pipeline o_count.
- o_busy  out  1  1 whenever state is not IDLE.
- o_result_valid  out  1  one-cycle result strobe.
- o_result  out  8  latched blob count.
- o_result_err  out  1  underrun/restart flag for the latched result.
- o_timeout  out  1  sticky timeout flag, cleared only by i_rst.

Behaviour:
- All outputs are registered and reset to 0. The state machine resets to IDLE, and all counters reset to 0.
- States: IDLE, ARM, STREAM, FLUSH, WAIT_RES, RELEASE, DONE, HALT.
- IDLE:
  - i_start → ARM.
  - The error flag is cleared on entry to ARM.
- ARM:
  - Waits for i_pix_valid & i_frame_start. In that cycle T:
    - i_threshold is sampled into thr_q.
    - pixel 0 is accepted and pix_cnt is set to 1.
    - the state goes to STREAM.
  - Pixels arriving without a frame start are ignored.
- Alignment:
  - o_blob_valid rises at T+1 and stays 1 until RELEASE.
  - Pixel k is accepted at cycle T+k and appears on o_blob_seq at cycle T+2+k, through a two-stage delay.
  - bin(p) = (p >= thr_q).
  - o_blob_seq is 0 whenever no accepted pixel occupies the delay slot.
- STREAM:
  - The block must see one pixel every cycle; pix_cnt counts to IMG_COL*IMG_ROW (20-bit counter).
  - After the last pixel is accepted → FLUSH.
  - If i_pix_valid=0 in STREAM (underrun): err is set, and the block substitutes bin=0 for that pixel and all remaining pixels of the frame. The pipeline is never starved and the pixel count still completes. The state goes to FLUSH after pix_cnt reaches the frame size.
  - If i_frame_start=1 in STREAM after pixel 0 (restart): err is set and the pixel is treated as an ordinary pixel.
- FLUSH:
  - Holds o_blob_seq=0 for 2 cycles to drain the delay line, then → WAIT_RES with to_cnt=0.
- WAIT_RES:
  - o_blob_seq=0 and to_cnt increments each cycle.
  - i_blob_done=1 → o_result is latched from i_blob_count and o_result_err from err; the state goes to RELEASE.
  - If to_cnt reaches TIMEOUT_CYC-1 without done → o_timeout=1, o_blob_valid=0, state HALT.
- HALT:
  - Terminal state; o_busy=1.
  - The block leaves HALT only on i_rst.
  - i_start is ignored.
- RELEASE:
  - o_blob_valid=0.
  - The block waits until i_blob_done=0, which means the pipeline has returned to idle, then → DONE.
- DONE:
  - o_result_valid=1 for exactly one cycle.
  - Next state is ARM if i_continuous=1, else IDLE.
  - o_result and o_result_err hold their values until the next latch.
- Simultaneous events:
  - i_start outside IDLE is ignored.
  - i_frame_start in the same cycle as the DONE→ARM transition is not captured; capture begins from the next frame.
- Reset mid-operation:
  - i_rst forces IDLE and drops o_blob_valid immediately.
  - The pipeline must be reset by the same reset tree.

Test Plan:
- Run with IMG_COL=8, IMG_ROW=6, threshold 100. Set i_start and provide a contiguous frame with 3 separate bright rectangles; the pipeline model returns count 3. Required: o_blob_valid at T+1, pixel 0 on o_blob_seq at T+2, o_result=3, o_result_err=0, one o_result_valid pulse, o_busy=0 afterwards.
- Drive a pixel with gray=100, then one with gray=99, at threshold 100. Required: o_blob_seq=1 for the first pixel and 0 for the second, two cycles after each pixel is accepted.
- Deassert i_pix_valid for 3 cycles at pixel 20. Required: the remaining pixels are streamed as 0, the total o_blob_seq slots equal 48, and o_result_err=1.
- With i_continuous=1, run two consecutive frames returning counts 2 and 5. Required: two o_result_valid pulses with o_result=2 then 5, and no return to IDLE.
- With TIMEOUT_CYC=16 and i_blob_done held at 0 in WAIT_RES: o_timeout=1 at the 16th cycle, o_blob_valid=0, state HALT, and a later i_start is ignored. i_rst then clears all outputs.
- Assert i_rst in STREAM at pixel 10. Required: all outputs are 0 in the same cycle, and a new i_start followed by a frame completes normally.
